// File: rtl/icache_refill_ctrl.sv
// Instruction-cache miss/refill controller: detects fetch misses, reads one line
// from memory, streams the words into the data array and validates the tag on the last beat.
module icache_refill_ctrl #(
   parameter int LINE_WORDS = 4,
   parameter int ADDR_W     = 32
) (
   input  logic              clk_i,
   input  logic              reset_n_i,
   input  logic              fetch_en_i,
   input  logic [ADDR_W-1:0] pc_fi_i,
   input  logic              lookup_hit_i,
   output logic              instr_hit_fi_o,
   output logic              ic_repl_permit_o,
   output logic              mem_req_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   input  logic              mem_gnt_i,
   input  logic              mem_rvalid_i,
   input  logic [31:0]       mem_rdata_i,
   output logic              ic_we_o,
   output logic [ADDR_W-1:0] ic_waddr_o,
   output logic [31:0]       ic_wdata_o,
   output logic              ic_tag_we_o,
   output logic [31:0]       miss_count_o
);

   localparam int BEAT_W = $clog2(LINE_WORDS);
   localparam int OFFS_W = BEAT_W + 2;
   localparam logic [ADDR_W-1:0] LINE_MASK = {ADDR_W{1'b1}} << OFFS_W;
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_FILL = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   state_t            state_r;
   state_t            state_nxt_s;
   logic [BEAT_W-1:0] beat_cnt_r;
   logic [ADDR_W-1:0] miss_addr_r;
   logic [31:0]       miss_count_r;

   logic              hit_s;
   logic              permit_s;
   logic              req_s;
   logic              we_s;
   logic              tag_we_s;
   logic              take_miss_s;
   logic              grant_s;
   logic              beat_s;
   logic [ADDR_W-1:0] beat_offs_s;

   // Next-state and per-state output decode.
   always_comb begin
      state_nxt_s = state_r;
      hit_s       = 1'b0;
      permit_s    = 1'b0;
      req_s       = 1'b0;
      we_s        = 1'b0;
      tag_we_s    = 1'b0;
      take_miss_s = 1'b0;
      grant_s     = 1'b0;
      beat_s      = 1'b0;
      case (state_r)
         ST_IDLE: begin
            hit_s    = lookup_hit_i | ~fetch_en_i;
            permit_s = 1'b1;
            if (fetch_en_i & ~lookup_hit_i) begin
               take_miss_s = 1'b1;
               state_nxt_s = ST_REQ;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_REQ: begin
            req_s = 1'b1;
            if (mem_gnt_i) begin
               grant_s     = 1'b1;
               state_nxt_s = ST_FILL;
            end else begin
               state_nxt_s = ST_REQ;
            end
         end
         ST_FILL: begin
            if (mem_rvalid_i) begin
               beat_s = 1'b1;
               we_s   = 1'b1;
               if (beat_cnt_r == LAST_BEAT) begin
                  tag_we_s    = 1'b1;
                  state_nxt_s = ST_DONE;
               end else begin
                  state_nxt_s = ST_FILL;
               end
            end else begin
               state_nxt_s = ST_FILL;
            end
         end
         ST_DONE: begin
            state_nxt_s = ST_IDLE;
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // State, beat counter, miss address and miss counter registers.
   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         state_r      <= ST_IDLE;
         beat_cnt_r   <= {BEAT_W{1'b0}};
         miss_addr_r  <= {ADDR_W{1'b0}};
         miss_count_r <= 32'd0;
      end else begin
         state_r <= state_nxt_s;
         if (take_miss_s) begin
            miss_addr_r  <= pc_fi_i & LINE_MASK;
            miss_count_r <= miss_count_r + 32'd1;
         end
         if (grant_s) begin
            beat_cnt_r <= {BEAT_W{1'b0}};
         end else if (beat_s) begin
            beat_cnt_r <= beat_cnt_r + BEAT_W'(1);
         end
      end
   end

   assign beat_offs_s = ADDR_W'({beat_cnt_r, 2'b00});

   // Bus and array strobes are suppressed while reset is asserted so an aborted
   // refill can never write or validate a line on its way back to idle.
   assign instr_hit_fi_o   = hit_s;
   assign ic_repl_permit_o = permit_s;
   assign mem_req_o        = req_s & reset_n_i;
   assign mem_addr_o       = miss_addr_r;
   assign ic_we_o          = we_s & reset_n_i;
   assign ic_tag_we_o      = tag_we_s & reset_n_i;
   assign ic_waddr_o       = miss_addr_r + beat_offs_s;
   assign ic_wdata_o       = mem_rdata_i;
   assign miss_count_o     = miss_count_r;

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Scoreboard bench for icache_refill_ctrl: expected array writes are queued as
// memory beats are driven and retired as the controller issues ic_we_o.
module tb_icache_refill_ctrl;

   logic        clk = 1'b0;
   logic        reset_n_i;
   logic        fetch_en_i;
   logic [31:0] pc_fi_i;
   logic        lookup_hit_i;
   logic        instr_hit_fi_o;
   logic        ic_repl_permit_o;
   logic        mem_req_o;
   logic [31:0] mem_addr_o;
   logic        mem_gnt_i;
   logic        mem_rvalid_i;
   logic [31:0] mem_rdata_i;
   logic        ic_we_o;
   logic [31:0] ic_waddr_o;
   logic [31:0] ic_wdata_o;
   logic        ic_tag_we_o;
   logic [31:0] miss_count_o;

   always #5 clk = ~clk;

   icache_refill_ctrl #(.LINE_WORDS(4), .ADDR_W(32)) dut (
      .clk_i            (clk),
      .reset_n_i        (reset_n_i),
      .fetch_en_i       (fetch_en_i),
      .pc_fi_i          (pc_fi_i),
      .lookup_hit_i     (lookup_hit_i),
      .instr_hit_fi_o   (instr_hit_fi_o),
      .ic_repl_permit_o (ic_repl_permit_o),
      .mem_req_o        (mem_req_o),
      .mem_addr_o       (mem_addr_o),
      .mem_gnt_i        (mem_gnt_i),
      .mem_rvalid_i     (mem_rvalid_i),
      .mem_rdata_i      (mem_rdata_i),
      .ic_we_o          (ic_we_o),
      .ic_waddr_o       (ic_waddr_o),
      .ic_wdata_o       (ic_wdata_o),
      .ic_tag_we_o      (ic_tag_we_o),
      .miss_count_o     (miss_count_o)
   );

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
      logic        tag;
   } wr_t;

   wr_t         exp_q[$];
   int          n_checks = 0;
   int          n_errors = 0;
   int          we_cnt = 0, tag_cnt = 0, hit_low_cnt = 0, permit_low_cnt = 0, req_cnt = 0;
   logic [31:0] req_addr_exp = 32'd0;
   logic        s_hit, s_permit, s_req;
   logic [31:0] s_miss;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
      end
   endtask

   // One clock: sample and score outputs on the falling edge, return 1ns after the rising edge.
   task automatic tick();
      wr_t e;
      @(negedge clk);
      s_hit    = instr_hit_fi_o;
      s_permit = ic_repl_permit_o;
      s_req    = mem_req_o;
      s_miss   = miss_count_o;
      if (ic_we_o === 1'b1) begin
         we_cnt++;
         if (exp_q.size() == 0) begin
            check_eq("spurious_we", 32'(ic_we_o), 32'd0);
         end else begin
            e = exp_q.pop_front();
            check_eq("waddr", ic_waddr_o, e.addr);
            check_eq("wdata", ic_wdata_o, e.data);
            check_eq("tag_we", 32'(ic_tag_we_o), 32'(e.tag));
         end
      end else if (ic_tag_we_o === 1'b1) begin
         check_eq("tag_without_we", 32'(ic_tag_we_o), 32'd0);
      end
      if (ic_tag_we_o === 1'b1) tag_cnt++;
      if (instr_hit_fi_o === 1'b0) hit_low_cnt++;
      if (ic_repl_permit_o === 1'b0) permit_low_cnt++;
      if (mem_req_o === 1'b1) begin
         req_cnt++;
         check_eq("req_addr", mem_addr_o, req_addr_exp);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_n_i    = 1'b0;
      mem_gnt_i    = 1'b0;
      mem_rvalid_i = 1'b0;
      tick();
      tick();
      reset_n_i = 1'b1;
   endtask

   task automatic start_miss(input logic [31:0] pc);
      fetch_en_i   = 1'b1;
      lookup_hit_i = 1'b0;
      pc_fi_i      = pc;
      req_addr_exp = pc & 32'hFFFF_FFF0;
      tick();
   endtask

   task automatic grant_after(input int wait_cycles);
      mem_gnt_i = 1'b0;
      repeat (wait_cycles) tick();
      mem_gnt_i = 1'b1;
      tick();
      mem_gnt_i = 1'b0;
   endtask

   task automatic beat(input logic [31:0] addr, input logic [31:0] data, input logic last);
      wr_t w;
      w.addr = addr;
      w.data = data;
      w.tag  = last;
      exp_q.push_back(w);
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = data;
      tick();
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = 32'd0;
   endtask

   int h0, w0, t0, r0, p0;

   initial begin
      reset_n_i    = 1'b0;
      fetch_en_i   = 1'b1;
      lookup_hit_i = 1'b1;
      pc_fi_i      = 32'd0;
      mem_gnt_i    = 1'b0;
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = 32'd0;
      @(posedge clk);
      #1;

      // Reset state with a hitting fetch presented.
      do_reset();
      tick();
      check_eq("rst_hit", 32'(s_hit), 32'd1);
      check_eq("rst_permit", 32'(s_permit), 32'd1);
      check_eq("rst_req", 32'(s_req), 32'd0);
      check_eq("rst_miss_cnt", s_miss, 32'd0);

      // Minimum-penalty refill.
      h0 = hit_low_cnt; w0 = we_cnt; t0 = tag_cnt; r0 = req_cnt;
      start_miss(32'h0000_1234);
      grant_after(0);
      for (int i = 0; i < 4; i++) beat(32'h0000_1230 + 32'(4 * i), 32'hA0 + 32'(i), (i == 3));
      lookup_hit_i = 1'b1;
      tick();
      tick();
      check_eq("min_hit_back", 32'(s_hit), 32'd1);
      check_eq("min_hit_low", 32'(hit_low_cnt - h0), 32'd7);
      check_eq("min_we_cnt", 32'(we_cnt - w0), 32'd4);
      check_eq("min_tag_cnt", 32'(tag_cnt - t0), 32'd1);
      check_eq("min_req_cycles", 32'(req_cnt - r0), 32'd1);
      check_eq("min_miss_cnt", s_miss, 32'd1);

      // Delayed grant and a gap between beats.
      h0 = hit_low_cnt; w0 = we_cnt; t0 = tag_cnt; r0 = req_cnt;
      start_miss(32'h0000_4008);
      grant_after(3);
      beat(32'h0000_4000, 32'hB0, 1'b0);
      beat(32'h0000_4004, 32'hB1, 1'b0);
      tick();
      tick();
      beat(32'h0000_4008, 32'hB2, 1'b0);
      beat(32'h0000_400C, 32'hB3, 1'b1);
      lookup_hit_i = 1'b1;
      tick();
      tick();
      check_eq("slow_hit_back", 32'(s_hit), 32'd1);
      check_eq("slow_hit_low", 32'(hit_low_cnt - h0), 32'd12);
      check_eq("slow_we_cnt", 32'(we_cnt - w0), 32'd4);
      check_eq("slow_tag_cnt", 32'(tag_cnt - t0), 32'd1);
      check_eq("slow_req_cycles", 32'(req_cnt - r0), 32'd4);
      check_eq("slow_miss_cnt", s_miss, 32'd2);

      // Fetch disabled with a missing lookup: no miss, hit reported.
      r0 = req_cnt;
      fetch_en_i   = 1'b0;
      lookup_hit_i = 1'b0;
      pc_fi_i      = 32'h0000_5000;
      repeat (3) tick();
      check_eq("noen_hit", 32'(s_hit), 32'd1);
      check_eq("noen_req_cycles", 32'(req_cnt - r0), 32'd0);
      check_eq("noen_miss_cnt", s_miss, 32'd2);
      fetch_en_i   = 1'b1;
      lookup_hit_i = 1'b1;
      tick();
      check_eq("idle_hit", 32'(s_hit), 32'd1);

      // Redirect mid-fill: first line completes, then the new PC misses.
      do_reset();
      w0 = we_cnt; t0 = tag_cnt;
      start_miss(32'h0000_1100);
      p0 = permit_low_cnt;
      grant_after(0);
      beat(32'h0000_1100, 32'hC0, 1'b0);
      beat(32'h0000_1104, 32'hC1, 1'b0);
      pc_fi_i = 32'h0000_2000;
      beat(32'h0000_1108, 32'hC2, 1'b0);
      beat(32'h0000_110C, 32'hC3, 1'b1);
      tick();
      start_miss(32'h0000_2000);
      check_eq("redir_idle_permit", 32'(s_permit), 32'd1);
      grant_after(0);
      for (int i = 0; i < 4; i++) beat(32'h0000_2000 + 32'(4 * i), 32'hD0 + 32'(i), (i == 3));
      lookup_hit_i = 1'b1;
      tick();
      check_eq("redir_permit_low", 32'(permit_low_cnt - p0), 32'd12);
      tick();
      check_eq("redir_hit_back", 32'(s_hit), 32'd1);
      check_eq("redir_miss_cnt", s_miss, 32'd2);
      check_eq("redir_we_cnt", 32'(we_cnt - w0), 32'd8);
      check_eq("redir_tag_cnt", 32'(tag_cnt - t0), 32'd2);

      // Reset after two beats: no tag write, stray beats ignored.
      do_reset();
      start_miss(32'h0000_3000);
      grant_after(0);
      beat(32'h0000_3000, 32'hE0, 1'b0);
      beat(32'h0000_3004, 32'hE1, 1'b0);
      w0 = we_cnt; t0 = tag_cnt;
      reset_n_i    = 1'b0;
      lookup_hit_i = 1'b1;
      tick();
      reset_n_i    = 1'b1;
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 32'hDEAD_BEEF;
      tick();
      check_eq("abort_permit", 32'(s_permit), 32'd1);
      check_eq("abort_hit", 32'(s_hit), 32'd1);
      check_eq("abort_miss_cnt", s_miss, 32'd0);
      tick();
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = 32'd0;
      tick();
      check_eq("abort_we_cnt", 32'(we_cnt - w0), 32'd0);
      check_eq("abort_tag_cnt", 32'(tag_cnt - t0), 32'd0);
      check_eq("sb_drained", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/icache_refill_ctrl.md
# icache_refill_ctrl

Instruction-cache miss/refill controller in the fetch stage, directly upstream of the hazard unit. It watches the fetch-stage tag lookup, drives `instr_hit_fi_o` and `ic_repl_permit_o` (consumed as `instr_hit_fi_i` / `ic_repl_permit_i` by hazard control), and on a miss fetches one full cache line from memory. Each returned word is written into the cache data array, and the line is validated in the tag array on the last beat. It owns no storage arrays, only the refill FSM, the beat counter, the latched miss address and a miss counter.

## Interface
- `LINE_WORDS`, default 4: 32-bit words per cache line; power of two, 2..16.
- `ADDR_W`, default 32: byte address width.
- `clk_i` in 1: clock.
- `reset_n_i` in 1: synchronous, active-low reset.
- `fetch_en_i` in 1: the fetch stage is presenting a valid PC this cycle.
- `pc_fi_i` in ADDR_W: fetch PC, word aligned.
- `lookup_hit_i` in 1: tag match with a valid line for `pc_fi_i` (combinational from the arrays).
- `instr_hit_fi_o` out 1: fetched instruction is valid this cycle; low means the pipeline stalls.
- `ic_repl_permit_o` out 1: no refill in flight; a redirect flush is permitted.
- `mem_req_o` out 1: line-read request.
- `mem_addr_o` out ADDR_W: line-aligned request address.
- `mem_gnt_i` in 1: request accepted; the handshake completes when `mem_req_o & mem_gnt_i`.
- `mem_rvalid_i` in 1: one returned word this cycle.
- `mem_rdata_i` in 32: returned word.
- `ic_we_o` out 1: data-array word write strobe.
- `ic_waddr_o` out ADDR_W: byte address of the word being written.
- `ic_wdata_o` out 32: equals `mem_rdata_i`.
- `ic_tag_we_o` out 1: write tag and set valid for the line at `ic_waddr_o`.
- `miss_count_o` out 32: number of misses taken since reset.

## Operation
- The FSM has four states: IDLE, REQ, FILL, DONE.
- IDLE:
  - `instr_hit_fi_o` = `lookup_hit_i | ~fetch_en_i`.
  - `ic_repl_permit_o` = 1.
  - When `fetch_en_i & ~lookup_hit_i`: latch `miss_addr` = `pc_fi_i` with the low log2(LINE_WORDS)+2 bits cleared, increment `miss_count_o` (wraps at 2^32), go to REQ.
- REQ:
  - `mem_req_o` = 1 and `mem_addr_o` = `miss_addr`, held stable until granted.
  - On `mem_gnt_i`: clear `beat_cnt`, go to FILL.
- FILL:
  - Each `mem_rvalid_i` cycle: `ic_we_o` = 1, `ic_waddr_o` = `miss_addr + 4*beat_cnt`, then `beat_cnt++`.
  - On the beat with `beat_cnt == LINE_WORDS-1`: also `ic_tag_we_o` = 1, then go to DONE.
  - Cycles without `mem_rvalid_i` write nothing and keep the FSM in FILL.
- DONE: one cycle for the array write to settle, then IDLE. The lookup is re-evaluated there and now hits.
- In REQ, FILL and DONE: `instr_hit_fi_o` = 0 and `ic_repl_permit_o` = 0, whatever `fetch_en_i` and `lookup_hit_i` are.
- `mem_rvalid_i` is ignored outside FILL. `mem_gnt_i` is ignored outside REQ.
- Redirect (PC change) during REQ, FILL or DONE: the refill always completes; there is no bus abort. The new PC is looked up on return to IDLE.
- `ic_tag_we_o` fires only on the final beat, so a partially filled line is never valid.

## Timing
- Reset (`reset_n_i` = 0 at a rising edge):
  - State = IDLE; `beat_cnt` = 0; `miss_addr` = 0; `miss_count_o` = 0.
  - `mem_req_o`, `ic_we_o` and `ic_tag_we_o` = 0.
  - `ic_repl_permit_o` = 1; `instr_hit_fi_o` follows the IDLE equation.
- Reset mid-refill: the FSM returns to IDLE immediately and no tag write occurs. Any memory beats still outstanding after reset are ignored.
- Miss sampled at edge T: REQ during T+1. A grant at the end of cycle G puts FILL in G+1.
- Last beat written in cycle L: DONE in L+1, IDLE in L+2. `instr_hit_fi_o` is high at L+2 at the earliest.
- Minimum miss penalty (grant in the first REQ cycle, back-to-back beats): `instr_hit_fi_o` is low for LINE_WORDS+3 cycles, i.e. 7 cycles at the default.
- A hit in IDLE has zero added latency, because `instr_hit_fi_o` is combinational in IDLE.
- A new miss can be taken in the same IDLE cycle the FSM returns; there is no dead cycle beyond DONE.

## Test plan
- Reset with `fetch_en_i`=1, `lookup_hit_i`=1 -> `instr_hit_fi_o`=1, `ic_repl_permit_o`=1, `mem_req_o`=0, `miss_count_o`=0.
- Miss at PC 0x0000_1234; grant in the first REQ cycle; 4 back-to-back beats 0xA0..0xA3 -> `mem_addr_o`=0x0000_1230; writes to 0x1230/0x1234/0x1238/0x123C with matching data; `ic_tag_we_o` only on the 0x123C beat; hit stays low 7 cycles; `miss_count_o`=1.
- Grant delayed 3 cycles and a 2-cycle gap between beats 1 and 2 -> `mem_addr_o` stable throughout REQ; no writes in gap cycles; hit low for 12 cycles; exactly 4 `ic_we_o` pulses.
- PC redirect to 0x0000_2000 mid-FILL with `lookup_hit_i`=0 -> the first line completes, then a second REQ at 0x0000_2000; `ic_repl_permit_o`=0 throughout both refills; `miss_count_o`=2.
- `reset_n_i` low after beat 2 -> next cycle IDLE, no `ic_tag_we_o` ever issued for that line; a stray `mem_rvalid_i` afterwards produces no `ic_we_o`.
- `fetch_en_i`=0 with `lookup_hit_i`=0 in IDLE -> no miss taken, `instr_hit_fi_o`=1, `miss_count_o` unchanged.
